// File: rtl/corefifo_rd_ctrl.sv
// Read-side pointer controller for the COREFIFO dual-port RAM: read pointers, empty, fill count, underflow, data valid.
// Optional almost-empty flag enabled by defining COREFIFO_RD_AEMPTY_EN.
module corefifo_rd_ctrl #(
    parameter int ADDRWIDTH = 3,
    parameter int RDLATENCY = 1,
    parameter int AEVAL     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDRWIDTH:0]   wptr_gray_sync,
    input  logic                 re,
    output logic [ADDRWIDTH-1:0] raddr,
    output logic [ADDRWIDTH:0]   rptr_gray,
    output logic                 empty,
    output logic [ADDRWIDTH:0]   rd_cnt,
    output logic                 underflow,
`ifdef COREFIFO_RD_AEMPTY_EN
    output logic                 aempty,
`endif
    output logic                 dvld
);

    localparam logic [ADDRWIDTH:0] DEPTH = {1'b1, {ADDRWIDTH{1'b0}}};

    function automatic logic [ADDRWIDTH:0] bin2gray(input logic [ADDRWIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [ADDRWIDTH:0] gray2bin(input logic [ADDRWIDTH:0] g);
        logic [ADDRWIDTH:0] b;
        b = '0;
        for (int i = 0; i <= ADDRWIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    if (!(RDLATENCY == 1 || RDLATENCY == 2)) begin : g_bad_latency
        $error("corefifo_rd_ctrl: RDLATENCY must be 1 or 2");
    end

    if (AEVAL < 1 || AEVAL >= (2 ** ADDRWIDTH)) begin : g_bad_aeval
        $error("corefifo_rd_ctrl: AEVAL must be in 1..2^ADDRWIDTH-1");
    end

    logic [ADDRWIDTH:0] wptr_bin;
    logic [ADDRWIDTH:0] rptr_bin;
    logic [ADDRWIDTH:0] rptr_next;
    logic [ADDRWIDTH:0] count_next;
    logic               rd_acc;

    always_comb begin
        wptr_bin   = gray2bin(wptr_gray_sync);
        rd_acc     = re & ~empty;
        rptr_next  = rptr_bin + {{ADDRWIDTH{1'b0}}, rd_acc};
        count_next = wptr_bin - rptr_next;
    end

    assign raddr = rptr_bin[ADDRWIDTH-1:0];

    // Stage p0 -> p1: pointer, flag and count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr_bin  <= '0;
            rptr_gray <= '0;
            empty     <= 1'b1;
            rd_cnt    <= '0;
            underflow <= 1'b0;
        end else begin
            rptr_bin  <= rptr_next;
            rptr_gray <= bin2gray(rptr_next);
            empty     <= (count_next == '0);
            rd_cnt    <= count_next;
            underflow <= re & empty;
        end
    end

`ifdef COREFIFO_RD_AEMPTY_EN
    localparam logic [ADDRWIDTH:0] AEVAL_W = AEVAL[ADDRWIDTH:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aempty <= 1'b1;
        end else begin
            aempty <= (count_next <= AEVAL_W);
        end
    end
`endif

    // Stage p1 -> p2: accepted reads delayed to line up with RAM output data
    if (RDLATENCY == 1) begin : g_lat1
        logic vld_p1;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) vld_p1 <= 1'b0;
            else       vld_p1 <= rd_acc;
        end
        assign dvld = vld_p1;
    end else if (RDLATENCY == 2) begin : g_lat2
        logic vld_p1;
        logic vld_p2;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_p1 <= 1'b0;
                vld_p2 <= 1'b0;
            end else begin
                vld_p1 <= rd_acc;
                vld_p2 <= vld_p1;
            end
        end
        assign dvld = vld_p2;
    end else begin : g_lat_none
        assign dvld = 1'b0;
    end

`ifndef SYNTHESIS
    // A count above the depth can only come from a corrupted synchronized write pointer.
    always @(posedge clk) begin
        if (!reset) assert (rd_cnt <= DEPTH);
    end
`endif

endmodule

// File: tb/tb_corefifo_rd_ctrl.sv
// Bench for corefifo_rd_ctrl: directed steps then random traffic, two instances (read latency 1 and 2)
// compared against an arithmetic pointer model.
module tb_corefifo_rd_ctrl;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW:0]   wg;
    logic          re;

    logic [AW-1:0] raddr1, raddr2;
    logic [AW:0]   rgray1, rgray2, cnt1, cnt2;
    logic          empty1, empty2, uf1, uf2, dv1, dv2;
`ifdef COREFIFO_RD_AEMPTY_EN
    logic          ae1, ae2;
`endif

    always #5 clk = ~clk;

    corefifo_rd_ctrl #(.ADDRWIDTH(AW), .RDLATENCY(1), .AEVAL(2)) u_dut1 (
        .clk(clk), .reset(reset), .wptr_gray_sync(wg), .re(re),
        .raddr(raddr1), .rptr_gray(rgray1), .empty(empty1), .rd_cnt(cnt1),
        .underflow(uf1),
`ifdef COREFIFO_RD_AEMPTY_EN
        .aempty(ae1),
`endif
        .dvld(dv1)
    );

    corefifo_rd_ctrl #(.ADDRWIDTH(AW), .RDLATENCY(2), .AEVAL(2)) u_dut2 (
        .clk(clk), .reset(reset), .wptr_gray_sync(wg), .re(re),
        .raddr(raddr2), .rptr_gray(rgray2), .empty(empty2), .rd_cnt(cnt2),
        .underflow(uf2),
`ifdef COREFIFO_RD_AEMPTY_EN
        .aempty(ae2),
`endif
        .dvld(dv2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pointers as plain integers modulo 16, count by subtraction.
    int m_rptr;
    int m_wbin;
    int m_cnt;
    bit m_empty;
    bit m_uf;
    bit acc_log [0:1023];
    int since;

    function automatic logic [AW:0] gray(input int b);
        int x;
        x = b ^ (b >> 1);
        return x[AW:0];
    endfunction

    function automatic bit exp_dv(input int lat);
        return (since >= lat) ? acc_log[since - lat] : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rptr  = 0;
        m_cnt   = 0;
        m_empty = 1'b1;
        m_uf    = 1'b0;
        since   = 0;
    endtask

    task automatic model_step(input bit r);
        bit acc;
        acc     = r && !m_empty;
        m_uf    = r && m_empty;
        m_rptr  = (m_rptr + int'(acc)) % 16;
        m_cnt   = (m_wbin - m_rptr + 16) % 16;
        m_empty = (m_cnt == 0);
        acc_log[since] = acc;
        since++;
    endtask

    task automatic check_all();
        chk("raddr1", 32'(raddr1), 32'(m_rptr % 8));
        chk("raddr2", 32'(raddr2), 32'(m_rptr % 8));
        chk("rgray1", 32'(rgray1), 32'(gray(m_rptr)));
        chk("rgray2", 32'(rgray2), 32'(gray(m_rptr)));
        chk("empty1", 32'(empty1), 32'(m_empty));
        chk("empty2", 32'(empty2), 32'(m_empty));
        chk("rd_cnt1", 32'(cnt1), 32'(m_cnt));
        chk("rd_cnt2", 32'(cnt2), 32'(m_cnt));
        chk("underflow1", 32'(uf1), 32'(m_uf));
        chk("underflow2", 32'(uf2), 32'(m_uf));
        chk("dvld_lat1", 32'(dv1), 32'(exp_dv(1)));
        chk("dvld_lat2", 32'(dv2), 32'(exp_dv(2)));
`ifdef COREFIFO_RD_AEMPTY_EN
        chk("aempty1", 32'(ae1), 32'(m_cnt <= 2));
        chk("aempty2", 32'(ae2), 32'(m_cnt <= 2));
`endif
    endtask

    task automatic do_cycle(input bit r, input int wb);
        re     = r;
        m_wbin = wb % 16;
        wg     = gray(m_wbin);
        @(posedge clk);
        model_step(r);
        #1;
        check_all();
    endtask

    initial begin
        int room;
        int adv;
        int target;

        reset = 1'b1;
        re    = 1'b0;
        wg    = '0;
        m_wbin = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_gray", 32'(rgray1), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // Read while empty: one underflow pulse, address does not move
        do_cycle(1'b1, 0);
        chk("uf_pulse", 32'(uf1), 32'(1));
        do_cycle(1'b0, 0);
        chk("uf_clear", 32'(uf1), 32'(0));

        // Five words written, then five consecutive reads
        do_cycle(1'b0, 5);
        chk("cnt_after_write", 32'(cnt1), 32'(5));
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 5);
        chk("empty_after_last", 32'(empty1), 32'(1));
        chk("gray_after_5", 32'(rgray1), 32'(4'b0111));
        do_cycle(1'b0, 5);
        do_cycle(1'b0, 5);

        // Full FIFO
        do_cycle(1'b0, 13);
        chk("full_cnt", 32'(cnt2), 32'(8));
        chk("full_empty", 32'(empty2), 32'(0));
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 13);

        // Pointer wrap 15 -> 0
        do_cycle(1'b0, 15);
        do_cycle(1'b1, 15);
        do_cycle(1'b1, 15);
        do_cycle(1'b0, 1);
        chk("wrap_gray_pre", 32'(rgray1), 32'(4'b1000));
        chk("wrap_raddr_pre", 32'(raddr1), 32'(7));
        chk("wrap_cnt_pre", 32'(cnt1), 32'(2));
        do_cycle(1'b1, 1);
        chk("wrap_gray_post", 32'(rgray1), 32'(4'b0000));
        chk("wrap_raddr_post", 32'(raddr1), 32'(0));
        chk("wrap_cnt_post", 32'(cnt1), 32'(1));

        // Write and read in the same cycle: count holds
        do_cycle(1'b0, 3);
        chk("sim_cnt_pre", 32'(cnt1), 32'(3));
        do_cycle(1'b1, 4);
        chk("sim_cnt_post", 32'(cnt1), 32'(3));

        // Random traffic, write pointer never more than a full FIFO ahead
        for (int i = 0; i < 300; i++) begin
            room = 8 - ((m_wbin - m_rptr + 16) % 16);
            adv  = $urandom_range(0, (room < 3) ? room : 3);
            do_cycle(1'($urandom_range(0, 1)), m_wbin + adv);
        end

        // Reset in the middle of a read burst
        target = (m_rptr + 6) % 16;
        do_cycle(1'b0, target);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, target);
        chk("burst_dvld2", 32'(dv2), 32'(1));
        #2;
        reset = 1'b1;
        wg    = '0;
        m_wbin = 0;
        #1;
        model_reset();
        check_all();
        chk("rst_dvld2", 32'(dv2), 32'(0));
        chk("rst_empty", 32'(empty2), 32'(1));
        @(negedge clk);
        reset = 1'b0;

        do_cycle(1'b0, 0);
        do_cycle(1'b0, 3);
        do_cycle(1'b1, 3);
        chk("post_rst_cnt", 32'(cnt2), 32'(2));
        do_cycle(1'b1, 3);
        do_cycle(1'b1, 3);
        do_cycle(1'b0, 3);
        do_cycle(1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
